fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO (`wr_rq`/`wdata`/`full`) among N write requesters.
- Sits in the write clock domain, between the requesters and the FIFO write side.
- Grants one requester at a time for a burst, which ends on the requester's `last`, on `MAX_BURST` accepted words, or when the requester withdraws.
- Stalls on FIFO full without losing data or ownership.

Parameters:
- WIDTH, 4, data word width; matches the FIFO `WIDTH`.
- N, 4, number of requesters; 2..8.
- MAX_BURST, 8, maximum words accepted per grant; must be ≥1 (elaboration error otherwise).

Ports:
- clk_in, input, 1, write-domain clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- req, input, N, per-requester write request; level, held while data is valid.
- wdata_in, input, N*WIDTH, packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- last, input, N, qualifies the final word of requester i's burst.
- fifo_full, input, 1, FIFO full flag.
- fifo_wr_rq, output, 1, write strobe to FIFO.
- fifo_wdata, output, WIDTH, data to FIFO.
- gnt, output, N, one-hot registered grant.
- ack, output, N, one-hot; requester i's word was accepted this cycle.
- owner, output, clog2(N) (min 1), index of current grantee; valid while busy=1.
- busy, output, 1, 1 in BURST state.

Behaviour:
- FSM states: ARB, BURST. Reset sets state=ARB, gnt=0, owner=0, burst count=0, rr pointer=N-1, busy=0.
- Outputs under reset: fifo_wr_rq=0, ack=0, fifo_wdata=0.
- ARB state:
  - If req==0, stay in ARB.
  - Otherwise select the first set req bit searching from (ptr+1) mod N upward with wrap.
  - Next edge: owner=sel, gnt=onehot(sel), burst count=0, state=BURST, ptr=sel.
  - ARB costs exactly one cycle. No writes occur in ARB.
- BURST state:
  - accept = req[owner] & ~fifo_full (combinational).
  - fifo_wr_rq=accept; ack=onehot(owner) when accept, else 0.
  - fifo_wdata = wdata_in slice[owner] whenever busy (0 otherwise), independent of full.
  - On accept the burst count increments.
- BURST exits to ARB, with gnt cleared on the same edge, when any of these holds:
  - accept & last[owner];
  - accept & count==MAX_BURST-1;
  - req[owner]==0, in which case no write occurs that cycle.
- fifo_full=1 in BURST: no write, no ack, count frozen, ownership kept indefinitely (no timeout).
- Simultaneous requests: no requester is granted twice while another holds req continuously. Worst-case wait is (N-1) bursts.
- Non-owner req changes during BURST are ignored until the next ARB.
- `last` is ignored when not accompanied by accept.
- Reset asserted mid-burst: the next edge returns to reset values. Any word presented in that cycle is not written. Port 0 wins the first arbitration after reset.
- Throughput: at most MAX_BURST words per MAX_BURST+1 cycles per grant.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- When defined, adds output port `word_cnt`, N*16 bits: per-requester 16-bit counters of accepted words.
  - Each counter increments on ack[i], wraps 0xFFFF→0, and clears on reset.
  - Also adds output `stall_cnt`, 16 bits: counts BURST cycles with req[owner]&fifo_full. It saturates at 0xFFFF and clears on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with req=4'b1111 → gnt=0, fifo_wr_rq=0, busy=0. First grant after release is owner=0, gnt=4'b0001, one cycle later.
- Round robin: req=4'b1111 held, last asserted on every requester's 2nd word, full=0 → grant order 0,1,2,3,0. Each burst writes 2 words, followed by 1 ARB cycle. ack matches owner.
- MAX_BURST cap (8): req[2]=1 only, last never asserted → exactly 8 writes, 1 ARB cycle, owner=2 regranted.
- Full stall: owner=1 accepted 3 words, then fifo_full=1 for 5 cycles → fifo_wr_rq=0 and ack=0 during the stall, owner stays 1, count stays 3. After full drops, 5 more words complete the 8-word burst.
- Withdrawal / reset mid-burst:
  - Owner drops req after 2 words → no write that cycle, return to ARB, next requester granted.
  - Separately, reset pulsed mid-burst with data 4'hA presented → 4'hA not written, owner=0 priority restored.
- FIFO_WR_ARB_STATS_EN: run the round-robin scenario for 3 full rotations → word_cnt[i]=6 for each i. 5 full-stall cycles → stall_cnt=5.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among N burst requesters.
// Define FIFO_WR_ARB_STATS_EN to add the word_cnt/stall_cnt statistics outputs.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata_in,
  input  logic [N-1:0]         last,
  input  logic                 fifo_full,
  output logic                 fifo_wr_rq,
  output logic [WIDTH-1:0]     fifo_wdata,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack,
  output logic [OW-1:0]        owner,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [N*16-1:0]      word_cnt,
  output logic [15:0]          stall_cnt,
`endif
  output logic                 busy
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
  end
  if (N < 2 || N > 8) begin : g_bad_n
    $error("fifo_wr_arbiter: N must be in 2..8");
  end

  typedef enum logic [0:0] {StArb, StBurst} state_e;

  state_e           r_state, w_state_d;
  logic [N-1:0]     r_gnt, w_gnt_d;
  logic [OW-1:0]    r_owner, w_owner_d;
  logic [OW-1:0]    r_ptr, w_ptr_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic [OW-1:0]    w_sel;
  logic             w_busy, w_own_req, w_own_last, w_accept, w_burst_end;

  // First set request strictly after the pointer, wrapping at N-1.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] idx;
    logic [OW-1:0] pick;
    logic          hit;
    idx  = p;
    pick = '0;
    hit  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (idx == OW'(N - 1)) ? '0 : idx + OW'(1);
      if (!hit && r[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
    return pick;
  endfunction

  assign w_sel      = rr_pick(req, r_ptr);
  assign w_busy     = (r_state == StBurst);
  assign w_own_req  = req[r_owner];
  assign w_own_last = last[r_owner];
  // A word presented while reset is asserted is never written.
  assign w_accept   = w_busy & w_own_req & ~fifo_full & ~reset;
  assign w_burst_end = ~w_own_req |
                       (w_accept & (w_own_last | (r_cnt == CW'(MAX_BURST - 1))));

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_owner_d = r_owner;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StArb: begin
        if (|req) begin
          w_state_d = StBurst;
          w_owner_d = w_sel;
          w_ptr_d   = w_sel;
          w_gnt_d   = N'(1) << w_sel;
          w_cnt_d   = '0;
        end
      end
      StBurst: begin
        if (w_accept) begin
          w_cnt_d = r_cnt + CW'(1);
        end
        if (w_burst_end) begin
          w_state_d = StArb;
          w_gnt_d   = '0;
        end
      end
      default: w_state_d = StArb;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= StArb;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= OW'(N - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_owner <= w_owner_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign fifo_wr_rq = w_accept;
  assign ack        = w_accept ? r_gnt : '0;
  assign fifo_wdata = (w_busy && !reset) ? wdata_in[r_owner*WIDTH +: WIDTH] : '0;
  assign gnt        = r_gnt;
  assign owner      = r_owner;
  assign busy       = w_busy;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] r_word_cnt;
  logic [15:0]     r_stall_cnt;
  logic            w_stall;

  assign w_stall = w_busy & w_own_req & fifo_full;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (ack[i]) begin
          r_word_cnt[i*16 +: 16] <= r_word_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign word_cnt  = r_word_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus hand sequences; written
// words are checked against a queue of expected data.
module tb_fifo_wr_arbiter;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned N         = 4;
  localparam int unsigned MAX_BURST = 8;

  logic                 clk_in = 1'b0;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   wdata_in;
  logic [N-1:0]         last;
  logic                 fifo_full;
  logic                 fifo_wr_rq;
  logic [WIDTH-1:0]     fifo_wdata;
  logic [N-1:0]         gnt;
  logic [N-1:0]         ack;
  logic [1:0]           owner;
  logic                 busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0]      word_cnt;
  logic [15:0]          stall_cnt;
`endif

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .N         (N),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .req        (req),
    .wdata_in   (wdata_in),
    .last       (last),
    .fifo_full  (fifo_full),
    .fifo_wr_rq (fifo_wr_rq),
    .fifo_wdata (fifo_wdata),
    .gnt        (gnt),
    .ack        (ack),
    .owner      (owner),
`ifdef FIFO_WR_ARB_STATS_EN
    .word_cnt   (word_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         full;
    logic         exp_wr;
    logic         exp_busy;
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_owner;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    last      = '0;
    fifo_full = 1'b0;
    wdata_in  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Every FIFO write must match the oldest expected word; ack must mirror the grant.
  always @(negedge clk_in) begin
    if (fifo_wr_rq === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h expected no write", fifo_wdata);
      end else begin
        chk("write_data", 64'(fifo_wdata), 64'(exp_q.pop_front()));
        chk("write_ack", 64'(ack), 64'(gnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [1:0] o;
    logic [3:0] oh;

    // Three rotations of 2-word bursts; non-owner last on word 1 must be ignored.
    v = '{req: 4'hF, last: 4'h0, full: 1'b0, exp_wr: 1'b0, exp_busy: 1'b0,
          exp_gnt: 4'h0, exp_owner: 2'd0};
    vecs.push_back(v);
    for (int b = 0; b < 12; b++) begin
      o  = 2'(b % 4);
      oh = 4'b0001 << o;
      v = '{req: 4'hF, last: ~oh, full: 1'b0, exp_wr: 1'b1, exp_busy: 1'b1,
            exp_gnt: oh, exp_owner: o};
      vecs.push_back(v);
      v.last = oh;
      vecs.push_back(v);
      v = '{req: 4'hF, last: 4'h0, full: 1'b0, exp_wr: 1'b0, exp_busy: 1'b0,
            exp_gnt: 4'h0, exp_owner: 2'd0};
      vecs.push_back(v);
    end

    reset     = 1'b1;
    req       = 4'hF;
    last      = '0;
    fifo_full = 1'b0;
    wdata_in  = 16'hAAAA;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      chk("reset_gnt", 64'(gnt), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_wr", 64'(fifo_wr_rq), 64'h0);
      chk("reset_wdata", 64'(fifo_wdata), 64'h0);
    end
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      req       = vecs[i].req;
      last      = vecs[i].last;
      fifo_full = vecs[i].full;
      for (int j = 0; j < N; j++) wdata_in[j*WIDTH +: WIDTH] = 4'(i + j);
      if (vecs[i].exp_wr) exp_q.push_back(wdata_in[vecs[i].exp_owner*WIDTH +: WIDTH]);
      settle();
      chk("rr_wr", 64'(fifo_wr_rq), 64'(vecs[i].exp_wr));
      chk("rr_busy", 64'(busy), 64'(vecs[i].exp_busy));
      chk("rr_gnt", 64'(gnt), 64'(vecs[i].exp_gnt));
      if (vecs[i].exp_busy) chk("rr_owner", 64'(owner), 64'(vecs[i].exp_owner));
      tick();
    end
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stats_word_cnt", 64'(word_cnt), 64'h0006_0006_0006_0006);
`endif

    // MAX_BURST cap with a single requester that never asserts last.
    do_reset();
    req = 4'b0100;
    settle();
    chk("cap_arb_busy", 64'(busy), 64'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      wdata_in = 16'(k * 16'h1111);
      exp_q.push_back(4'(k));
      settle();
      chk("cap_wr", 64'(fifo_wr_rq), 64'h1);
      chk("cap_owner", 64'(owner), 64'h2);
      tick();
    end
    settle();
    chk("cap_rearb_busy", 64'(busy), 64'h0);
    chk("cap_rearb_wr", 64'(fifo_wr_rq), 64'h0);
    tick();
    req = 4'b0000;
    settle();
    chk("cap_regrant_owner", 64'(owner), 64'h2);
    chk("cap_regrant_gnt", 64'(gnt), 64'h4);
    chk("cap_withdrawn_wr", 64'(fifo_wr_rq), 64'h0);
    tick();

    // FIFO full stall in the middle of owner 1's burst.
    do_reset();
    req = 4'b0010;
    settle();
    tick();
    for (int k = 1; k <= 3; k++) begin
      wdata_in = 16'(k * 16'h1111);
      exp_q.push_back(4'(k));
      settle();
      chk("stall_pre_wr", 64'(fifo_wr_rq), 64'h1);
      tick();
    end
    fifo_full = 1'b1;
    wdata_in  = 16'hCCCC;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_wr", 64'(fifo_wr_rq), 64'h0);
      chk("stall_ack", 64'(ack), 64'h0);
      chk("stall_owner", 64'(owner), 64'h1);
      chk("stall_busy", 64'(busy), 64'h1);
      chk("stall_wdata", 64'(fifo_wdata), 64'hC);
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      wdata_in = 16'(k * 16'h1111);
      exp_q.push_back(4'(k));
      settle();
      chk("stall_post_wr", 64'(fifo_wr_rq), 64'h1);
      tick();
    end
    settle();
    chk("stall_exit_busy", 64'(busy), 64'h0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stats_stall_cnt", 64'(stall_cnt), 64'h5);
`endif
    tick();

    // Owner withdraws after two words; the other requester takes over.
    do_reset();
    req = 4'b0011;
    settle();
    tick();
    for (int k = 1; k <= 2; k++) begin
      wdata_in = 16'(k * 16'h1111);
      exp_q.push_back(4'(k));
      settle();
      chk("wd_owner", 64'(owner), 64'h0);
      tick();
    end
    req = 4'b0010;
    settle();
    chk("wd_drop_wr", 64'(fifo_wr_rq), 64'h0);
    chk("wd_drop_ack", 64'(ack), 64'h0);
    chk("wd_drop_busy", 64'(busy), 64'h1);
    tick();
    settle();
    chk("wd_arb_busy", 64'(busy), 64'h0);
    tick();
    wdata_in = 16'h5555;
    exp_q.push_back(4'h5);
    settle();
    chk("wd_next_owner", 64'(owner), 64'h1);
    chk("wd_next_gnt", 64'(gnt), 64'h2);
    tick();

    // Reset pulsed mid-burst: the presented 4'hA must not be written.
    do_reset();
    req = 4'b0100;
    settle();
    tick();
    wdata_in = 16'h1111;
    exp_q.push_back(4'h1);
    settle();
    tick();
    reset    = 1'b1;
    wdata_in = 16'hAAAA;
    settle();
    chk("rst_mid_wr", 64'(fifo_wr_rq), 64'h0);
    chk("rst_mid_wdata", 64'(fifo_wdata), 64'h0);
    tick();
    reset    = 1'b0;
    req      = 4'b0101;
    wdata_in = 16'h3333;
    settle();
    chk("rst_after_busy", 64'(busy), 64'h0);
    chk("rst_after_gnt", 64'(gnt), 64'h0);
    tick();
    exp_q.push_back(4'h3);
    settle();
    chk("rst_prio_owner", 64'(owner), 64'h0);
    chk("rst_prio_gnt", 64'(gnt), 64'h1);
    tick();

    do_reset();
    settle();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
